// File: rtl/fir_queue_engine_if.sv
// rtl/fir_queue_engine_if.sv - sample, coefficient and result bundle for fir_queue_engine
//
// master: sample source / coefficient writer (drives smpl_in, wrt_smpl, byp,
//         coef_wr, coef_addr, coef_data; observes filt_out, out_vld, busy,
//         full, ovfl)
// slave : the filter engine (opposite directions)
interface fir_queue_engine_if #(
  parameter int W     = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 1021,
  parameter int CHNLS = 2
);
  logic [CHNLS*W-1:0]      smpl_in;
  logic                    wrt_smpl;
  logic                    byp;
  logic                    coef_wr;
  logic [$clog2(TAPS)-1:0] coef_addr;
  logic [CW-1:0]           coef_data;
  logic [CHNLS*W-1:0]      filt_out;
  logic                    out_vld;
  logic                    busy;
  logic                    full;
  logic                    ovfl;

  modport master (
    output smpl_in, wrt_smpl, byp, coef_wr, coef_addr, coef_data,
    input  filt_out, out_vld, busy, full, ovfl
  );

  modport slave (
    input  smpl_in, wrt_smpl, byp, coef_wr, coef_addr, coef_data,
    output filt_out, out_vld, busy, full, ovfl
  );
endinterface

// File: rtl/fir_queue_engine.sv
// rtl/fir_queue_engine.sv - per-channel circular sample queue with shared-coefficient FIR
//
// Keeps the last TAPS samples of every channel and, once the history is full,
// convolves it with a run-time-written coefficient RAM (all channels in
// parallel). One filtered word per channel per accepted sample, TAPS+3 cycles
// after the strobe. Bypass copies the input straight to the output.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - fir_queue_engine_if.slave
//         in : smpl_in, wrt_smpl, byp, coef_wr, coef_addr, coef_data
//         out: filt_out, out_vld, busy, full, ovfl
module fir_queue_engine #(
  parameter int W     = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 1021,
  parameter int CHNLS = 2
) (
  input  logic              clk,
  input  logic              rst,
  fir_queue_engine_if.slave bus
);
  localparam int AI    = $clog2(TAPS);
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam int PW    = W + CW;
  localparam int AW    = W + CW + AI;
  localparam logic [AI-1:0]       LAST_IDX = AI'(TAPS - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0]    CNT_TRIG = CNT_W'(TAPS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_next;

  logic [CHNLS*W-1:0]     smem [TAPS];
  logic signed [CW-1:0]   coef [TAPS];
  logic [AI-1:0]          wptr, rd_ptr;
  logic [CNT_W-1:0]       cnt, step;
  logic [CHNLS*W-1:0]     x_q;
  logic signed [CW-1:0]   c_q;
  logic                   rd_vld;
  logic signed [AW-1:0]   acc [CHNLS];
  logic signed [PW-1:0]   prod [CHNLS];
  logic [CHNLS*W-1:0]     sat_out;
  logic [CHNLS*W-1:0]     filt_q;
  logic                   out_vld_q, busy_q, ovfl_q;
  logic                   accept, trigger, mac_issue;

  // busy_q is the registered busy flag; samples arriving while it is high are dropped.
  assign accept  = bus.wrt_smpl && !busy_q;
  // Trigger when this write leaves the queue full (cnt already TAPS-1 or TAPS).
  assign trigger = accept && !bus.byp && (cnt >= CNT_TRIG);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // MAC spends TAPS cycles issuing reads plus one to drain the last product.
  always_comb begin
    state_next = state;
    mac_issue  = 1'b0;
    unique case (state)
      IDLE: if (trigger) state_next = MAC;
      MAC: begin
        if (step == CNT_FULL) state_next = DONE;
        else                  mac_issue  = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sample and coefficient storage (no reset), registered read port.
  always_ff @(posedge clk) begin
    if (accept) smem[wptr] <= bus.smpl_in;
    if (bus.coef_wr && !busy_q) coef[bus.coef_addr] <= bus.coef_data;
    if (mac_issue) begin
      x_q <= smem[rd_ptr];
      c_q <= coef[step[AI-1:0]];
    end
  end

  // Full-precision signed products from the registered read data.
  always_comb begin
    for (int c = 0; c < CHNLS; c++) begin
      prod[c] = $signed({{CW{x_q[c*W+W-1]}}, x_q[c*W +: W]}) *
                $signed({{W{c_q[CW-1]}}, c_q});
    end
  end

  // Q1.(CW-1) rescale (floor) and clamp to the W-bit signed range.
  always_comb begin
    logic signed [AW-1:0] shifted;
    shifted = '0;
    sat_out = '0;
    for (int c = 0; c < CHNLS; c++) begin
      shifted = acc[c] >>> (CW - 1);
      if (shifted > SAT_MAX)      sat_out[c*W +: W] = {1'b0, {(W-1){1'b1}}};
      else if (shifted < SAT_MIN) sat_out[c*W +: W] = {1'b1, {(W-1){1'b0}}};
      else                        sat_out[c*W +: W] = shifted[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wptr      <= '0;
      rd_ptr    <= '0;
      step      <= '0;
      rd_vld    <= 1'b0;
      filt_q    <= '0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      ovfl_q    <= 1'b0;
      for (int c = 0; c < CHNLS; c++) acc[c] <= '0;
    end else begin
      out_vld_q <= 1'b0;
      // Held one cycle past DONE so busy covers the out_vld cycle too.
      busy_q    <= (state_next != IDLE) || (state == DONE);
      rd_vld    <= mac_issue;
      if (bus.wrt_smpl && busy_q) ovfl_q <= 1'b1;

      if (accept) begin
        wptr <= (wptr == LAST_IDX) ? '0 : wptr + AI'(1);
        if (cnt != CNT_FULL) cnt <= cnt + CNT_W'(1);
        if (bus.byp) begin
          filt_q    <= bus.smpl_in;
          out_vld_q <= 1'b1;
        end
      end

      if (state == IDLE && trigger) begin
        rd_ptr <= wptr;  // slot being written this cycle = newest sample
        step   <= '0;
        for (int c = 0; c < CHNLS; c++) acc[c] <= '0;
      end else if (rd_vld) begin
        for (int c = 0; c < CHNLS; c++) acc[c] <= acc[c] + AW'(prod[c]);
      end

      if (mac_issue) begin
        rd_ptr <= (rd_ptr == '0) ? LAST_IDX : rd_ptr - AI'(1);
        step   <= step + CNT_W'(1);
      end

      if (state == DONE) begin
        filt_q    <= sat_out;
        out_vld_q <= 1'b1;
      end
    end
  end

  assign bus.filt_out = filt_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.busy     = busy_q;
  assign bus.full     = (cnt == CNT_FULL);
  assign bus.ovfl     = ovfl_q;
endmodule

// File: tb/tb_fir_queue_engine.sv
// tb/tb_fir_queue_engine.sv - self-checking bench for fir_queue_engine
module tb_fir_queue_engine;
  localparam int W = 16, CW = 16, TAPS = 4, CHNLS = 2, L = TAPS + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_queue_engine_if #(.W(W), .CW(CW), .TAPS(TAPS), .CHNLS(CHNLS)) bus();
  fir_queue_engine #(.W(W), .CW(CW), .TAPS(TAPS), .CHNLS(CHNLS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: newest-first history per channel and the coefficient set.
  int mcoef [TAPS];
  int h0[$];
  int h1[$];

  function automatic logic [15:0] model_fir(input int ch);
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < TAPS; k++)
      s += longint'(ch == 0 ? h0[k] : h1[k]) * longint'(mcoef[k]);
    r = s >>> (CW - 1);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic model_write(input logic [31:0] s, input logic b,
                             output logic ev, output logic [31:0] exv);
    h0.push_front(int'($signed(s[15:0])));
    h1.push_front(int'($signed(s[31:16])));
    if (h0.size() > TAPS) begin
      void'(h0.pop_back());
      void'(h1.pop_back());
    end
    ev  = b || (h0.size() == TAPS);
    exv = b ? s : {model_fir(1), model_fir(0)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wrt_smpl = 1'b0;
    bus.coef_wr  = 1'b0;
    bus.byp      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    h0.delete();
    h1.delete();
  endtask

  task automatic set_coef(input int k, input logic [15:0] v, input logic upd);
    @(negedge clk);
    bus.coef_wr   = 1'b1;
    bus.coef_addr = 2'(k);
    bus.coef_data = v;
    @(negedge clk);
    bus.coef_wr = 1'b0;
    if (upd) mcoef[k] = int'($signed(v));
  endtask

  task automatic strobe_only(input logic [31:0] s);
    @(negedge clk);
    bus.smpl_in  = s;
    bus.wrt_smpl = 1'b1;
    @(negedge clk);
    bus.wrt_smpl = 1'b0;
  endtask

  // n = negedges after the strobe edge's first negedge (bypass 0, filtered TAPS+2).
  task automatic push(input logic [31:0] s, input logic b, output logic got,
                      output int n, output logic [31:0] val, output logic bsy);
    @(negedge clk);
    bus.smpl_in  = s;
    bus.byp      = b;
    bus.wrt_smpl = 1'b1;
    @(negedge clk);
    bus.wrt_smpl = 1'b0;
    got = 1'b0; n = -1; val = '0; bsy = 1'b0;
    for (int i = 0; i < TAPS + 8; i++) begin
      if (bus.out_vld) begin
        got = 1'b1; n = i; val = bus.filt_out; bsy = bus.busy;
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i < TAPS + 8 && bus.busy; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b exp 0", bus.out_vld); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
    checks++; if (bus.ovfl !== 1'b0) begin errors++; $display("FAIL reset_ovfl got %b exp 0", bus.ovfl); end
    checks++; if (bus.filt_out !== 32'h0) begin errors++; $display("FAIL reset_filt_out got %h exp 0", bus.filt_out); end
  endtask

  task automatic test_single_tap();
    logic got, bsy, ev;
    int n;
    logic [31:0] val, exv;
    do_reset();
    set_coef(0, 16'h4000, 1); set_coef(1, 16'h0, 1); set_coef(2, 16'h0, 1); set_coef(3, 16'h0, 1);
    for (int i = 1; i <= 5; i++) begin
      logic [15:0] s;
      s = 16'(i * 100);
      model_write({s, s}, 1'b0, ev, exv);
      push({s, s}, 1'b0, got, n, val, bsy);
      checks++; if (got !== (i >= 4)) begin errors++; $display("FAIL single_tap_vld[%0d] got %b exp %b", i, got, i >= 4); end
      if (i == 4) begin
        checks++; if (n + 1 !== L) begin errors++; $display("FAIL single_tap_latency got %0d exp %0d", n + 1, L); end
        checks++; if (val !== 32'h00C8_00C8) begin errors++; $display("FAIL single_tap_200 got %h exp 00c800c8", val); end
        checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL busy_at_out_vld got %b exp 1", bsy); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL single_tap_full got %b exp 1", bus.full); end
      end
      if (i == 5) begin
        checks++; if (val !== 32'h00FA_00FA) begin errors++; $display("FAIL single_tap_250 got %h exp 00fa00fa", val); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_after_out got %b exp 0", bus.busy); end
      end
    end
  endtask

  task automatic test_wrap();
    logic got, bsy;
    int n;
    logic [31:0] val;
    int ex [6];
    ex = '{0, 0, 0, 15, 20, 25};
    do_reset();
    set_coef(0, 16'h0, 1); set_coef(1, 16'h4000, 1); set_coef(2, 16'h0, 1); set_coef(3, 16'h0, 1);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] s;
      s = 16'((i + 1) * 10);
      push({s, s}, 1'b0, got, n, val, bsy);
      checks++; if (got !== (i >= 3)) begin errors++; $display("FAIL wrap_vld[%0d] got %b exp %b", i, got, i >= 3); end
      if (i >= 3) begin
        checks++; if (val !== {16'(ex[i]), 16'(ex[i])}) begin errors++; $display("FAIL wrap_val[%0d] got %h exp %0d", i, val, ex[i]); end
      end
    end
  endtask

  task automatic test_saturation();
    logic got, bsy;
    int n;
    logic [31:0] val;
    do_reset();
    for (int k = 0; k < TAPS; k++) set_coef(k, 16'h7FFF, 1);
    for (int i = 0; i < TAPS; i++) push({16'h8000, 16'h7FFF}, 1'b0, got, n, val, bsy);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL sat_vld got %b exp 1", got); end
    checks++; if (val !== 32'h8000_7FFF) begin errors++; $display("FAIL sat_val got %h exp 80007fff", val); end
  endtask

  task automatic test_overflow();
    logic got, bsy;
    int n, seen;
    logic [31:0] val;
    do_reset();
    set_coef(0, 16'h4000, 1); set_coef(1, 16'h4000, 1); set_coef(2, 16'h0, 1); set_coef(3, 16'h0, 1);
    push({16'd10, 16'd10}, 1'b0, got, n, val, bsy);
    push({16'd20, 16'd20}, 1'b0, got, n, val, bsy);
    push({16'd30, 16'd30}, 1'b0, got, n, val, bsy);
    strobe_only({16'd40, 16'd40});
    strobe_only({16'd999, 16'd999});
    checks++; if (bus.ovfl !== 1'b1) begin errors++; $display("FAIL ovfl_set got %b exp 1", bus.ovfl); end
    seen = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_vld) begin seen = i; val = bus.filt_out; break; end
      @(negedge clk);
    end
    checks++; if (seen + 3 !== L) begin errors++; $display("FAIL ovfl_inflight_latency got %0d exp %0d", seen + 3, L); end
    checks++; if (val !== {16'd35, 16'd35}) begin errors++; $display("FAIL ovfl_inflight_val got %h exp 00230023", val); end
    for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
    push({16'd50, 16'd50}, 1'b0, got, n, val, bsy);
    checks++; if (val !== {16'd45, 16'd45}) begin errors++; $display("FAIL ovfl_dropped_excluded got %h exp 002d002d", val); end
    checks++; if (bus.ovfl !== 1'b1) begin errors++; $display("FAIL ovfl_sticky got %b exp 1", bus.ovfl); end
  endtask

  task automatic test_reset_mid_mac();
    logic got, bsy;
    int n, vld_seen;
    logic [31:0] val;
    do_reset();
    set_coef(0, 16'h4000, 1); set_coef(1, 16'h0, 1); set_coef(2, 16'h0, 1); set_coef(3, 16'h0, 1);
    for (int i = 1; i <= 3; i++) push({16'(i), 16'(i)}, 1'b0, got, n, val, bsy);
    strobe_only({16'd4, 16'd4});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.filt_out !== 32'h0) begin errors++; $display("FAIL mid_rst_filt_out got %h exp 0", bus.filt_out); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL mid_rst_full got %b exp 0", bus.full); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", bus.busy); end
    vld_seen = 0;
    for (int i = 0; i < L + 4; i++) begin
      if (bus.out_vld) vld_seen++;
      @(negedge clk);
    end
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL mid_rst_no_out got %0d pulses exp 0", vld_seen); end
    for (int i = 5; i <= 8; i++) begin
      push({16'(i), 16'(i)}, 1'b0, got, n, val, bsy);
      checks++; if (got !== (i == 8)) begin errors++; $display("FAIL mid_rst_refill[%0d] got %b exp %b", i, got, i == 8); end
    end
    checks++; if (val !== {16'd4, 16'd4}) begin errors++; $display("FAIL mid_rst_resume_val got %h exp 00040004", val); end
  endtask

  task automatic test_bypass();
    logic got, bsy, ev;
    int n, seen;
    logic [31:0] val, exv;
    do_reset();
    set_coef(0, 16'h4000, 1); set_coef(1, 16'h0, 1); set_coef(2, 16'h0, 1); set_coef(3, 16'h0, 1);
    model_write(32'hABCD_1234, 1'b1, ev, exv);
    push(32'hABCD_1234, 1'b1, got, n, val, bsy);
    checks++; if (n !== 0) begin errors++; $display("FAIL byp_latency got %0d exp 0", n); end
    checks++; if (val !== 32'hABCD_1234) begin errors++; $display("FAIL byp_val got %h exp abcd1234", val); end
    checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL byp_busy got %b exp 0", bsy); end
    model_write({16'd60, 16'd60}, 1'b0, ev, exv);
    push({16'd60, 16'd60}, 1'b0, got, n, val, bsy);
    model_write({16'd70, 16'd70}, 1'b0, ev, exv);
    push({16'd70, 16'd70}, 1'b0, got, n, val, bsy);
    model_write({16'd80, 16'd80}, 1'b0, ev, exv);
    strobe_only({16'd80, 16'd80});
    set_coef(0, 16'h7FFF, 1'b0);
    seen = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_vld) begin seen = i; val = bus.filt_out; break; end
      @(negedge clk);
    end
    checks++; if (seen < 0 || val !== exv) begin errors++; $display("FAIL byp_fill_out got %h exp %h", val, exv); end
    for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
    model_write({16'd90, 16'd90}, 1'b0, ev, exv);
    push({16'd90, 16'd90}, 1'b0, got, n, val, bsy);
    checks++; if (val !== exv) begin errors++; $display("FAIL coef_wr_busy_ignored got %h exp %h", val, exv); end
  endtask

  task automatic test_random();
    logic got, bsy, ev, b;
    int n;
    logic [31:0] val, exv, s;
    do_reset();
    for (int k = 0; k < TAPS; k++) set_coef(k, 16'($urandom), 1);
    for (int i = 0; i < 30; i++) begin
      s = $urandom;
      b = ($urandom_range(0, 3) == 0);
      model_write(s, b, ev, exv);
      push(s, b, got, n, val, bsy);
      checks++; if (got !== ev) begin errors++; $display("FAIL rand_vld[%0d] got %b exp %b", i, got, ev); end
      if (ev && got) begin
        checks++; if (val !== exv) begin errors++; $display("FAIL rand_val[%0d] got %h exp %h", i, val, exv); end
        checks++; if (n !== (b ? 0 : TAPS + 2)) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, n, b ? 0 : TAPS + 2); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.smpl_in   = '0;
    bus.wrt_smpl  = 1'b0;
    bus.byp       = 1'b0;
    bus.coef_wr   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    test_reset();
    test_single_tap();
    test_wrap();
    test_saturation();
    test_overflow();
    test_reset_mid_mac();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_queue_engine.md
# fir_queue_engine

Parametrised successor to the fixed low-frequency queue + FIR pair. It holds a circular history of the last TAPS samples per channel and convolves that history with a run-time-programmable coefficient RAM. It emits one filtered sample per channel, per input sample, at fixed latency. It sits between the I2S slave (wrt_smpl = vld, samples = chnl[23:8]) and the equalizer summing stage, with any number of channels and a bypass mode.

## Interface
- W, 16, sample and output width (signed)
- CW, 16, coefficient width (signed Q1.(CW-1))
- TAPS, 1021, filter length = queue depth per channel (≥2)
- CHNLS, 2, channel count; all channels share coefficients
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- smpl_in  in  CHNLS*W  input samples, channel c at [c*W +: W]
- wrt_smpl  in  1  one-cycle strobe: smpl_in valid
- byp  in  1  bypass mode select
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index k (k=0 multiplies newest sample)
- coef_data  in  CW  coefficient value
- filt_out  out  CHNLS*W  filtered samples, same packing as smpl_in
- out_vld  out  1  one-cycle pulse: filt_out updated
- busy  out  1  convolution in progress
- full  out  1  queue holds TAPS valid samples
- ovfl  out  1  sticky: a wrt_smpl was dropped

## Operation
- Queue: one circular buffer per channel, TAPS entries, single write pointer wptr, fill count cnt (saturates at TAPS).
- Queue write: wrt_smpl while !busy stores every channel at wptr and advances wptr (TAPS-1 wraps to 0). cnt increments until TAPS. full = (cnt == TAPS).
- FSM states:
  - IDLE. A write that leaves cnt == TAPS with byp=0 goes to MAC.
  - MAC. Runs TAPS tap steps; step k reads x[n-k] (newest first, wrapping backward through the buffer) and coef[k]. It multiplies them, signed, and adds into a per-channel accumulator cleared at MAC entry. All channels run in parallel.
  - DONE. Scales, saturates and registers filt_out, pulses out_vld, then returns to IDLE.
- Arithmetic:
  - Accumulator width is W+CW+clog2(TAPS), with no internal overflow.
  - Result = acc >>> (CW-1), arithmetic shift, truncation toward −∞.
  - The result saturates to [−2^(W-1), 2^(W-1)−1].
- Coefficient RAM:
  - Written only when !busy; coef_wr during busy is ignored.
  - Not cleared by rst; its contents are undefined until written.
  - coef_wr in the same cycle as a triggering wrt_smpl takes effect for that convolution.
- Bypass: with byp=1, wrt_smpl still writes the queue. filt_out <= smpl_in and out_vld pulses in the next cycle. No MAC is started.
  - byp changing during MAC has no effect until the next sample.
- Overflow: wrt_smpl while busy is dropped, with no queue or cnt change. ovfl is set and stays 1 until rst.
- Reset: clears cnt, wptr, FSM (to IDLE), accumulators, filt_out, out_vld, busy and ovfl to 0. Sample memory contents are don't-care.
  - Reset during MAC aborts with no out_vld.
  - The queue must refill TAPS samples before the next filtered output.

## Timing
- Filtered latency is fixed at L = TAPS+3: out_vld asserts in cycle t+L for a triggering wrt_smpl sampled at edge t.
  - The implementation may pipeline RAM read, multiply and accumulate internally but must meet L exactly.
- busy rises at t+1 and falls the cycle after out_vld (busy high for cycles t+1..t+L).
- Bypass latency: out_vld at t+1; busy stays 0.
- filt_out is held between out_vld pulses.
- full updates the cycle after the write that fills the queue.
- Writes before full (cnt < TAPS after the write) produce no output in non-bypass mode.
- Minimum sample spacing without drop: L+1 cycles.

## Test plan
Use TAPS=4, CHNLS=2, W=CW=16 unless stated; write all coefficients before samples.
- Single tap: coef={0x4000,0,0,0}; write 100,200,300,400 on both channels → first out_vld exactly 7 cycles after the 4th strobe, filt_out={200,200}. Next write 500 → 250.
- Ordering and wraparound: coef={0,0x4000,0,0}; samples 10,20,30,40,50,60 → outputs 15, 20, 25. Verifies x[n-1] selection across the wptr wrap.
- Saturation: coef all 0x7FFF; ch0 four × 0x7FFF, ch1 four × 0x8000 → filt_out={0x8000,0x7FFF}, with no wrap to the opposite sign.
- Overflow: strobe wrt_smpl 2 cycles after a triggering write → ovfl=1 sticky, sample ignored. The in-flight output is unchanged and the next valid write's result excludes the dropped sample.
- Reset mid-MAC: assert rst 3 cycles into MAC → no out_vld, all outputs 0, full=0. Outputs resume only after 4 new writes.
- Bypass: byp=1, smpl_in={0xABCD,0x1234}, strobe → next cycle filt_out={0xABCD,0x1234}, out_vld=1, busy=0. A coef_wr during busy in non-bypass mode leaves the coefficient unchanged.
